// File: rtl/pipe_skid_reg.sv
// Valid/ready pipeline register with a 2-entry skid buffer, flush and hold.
// in_ready_o depends only on registered state and hold_i, so there is no
// combinational path from out_ready_i back upstream.
module pipe_skid_reg #(
    parameter int unsigned    DW      = 32,
    parameter logic [DW-1:0]  SET_VAL = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    input  logic          hold_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] in_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_data_o,
    output logic [1:0]    count_o
);

    // State encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StBusy  = 2'd1,
        StFull  = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] main_q, main_d;
    logic [DW-1:0] skid_q, skid_d;
    logic          in_fire, out_fire;

    // Handshake outputs: hold_i is the only combinational term.
    always_comb begin
        in_ready_o  = (state_q != StFull) & ~hold_i;
        out_valid_o = (state_q != StEmpty) & ~hold_i;
        out_data_o  = main_q;
        count_o     = state_q;
        in_fire     = in_valid_i & in_ready_o;
        out_fire    = out_valid_o & out_ready_i;
    end

    // Next-state: flush beats hold, hold freezes everything.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = StEmpty;
            main_d  = SET_VAL;
        end else if (!hold_i) begin
            case (state_q)
                StEmpty: begin
                    if (in_fire) begin
                        state_d = StBusy;
                        main_d  = in_data_i;
                    end
                end
                StBusy: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data_i;
                    end else if (in_fire) begin
                        state_d = StFull;
                        skid_d  = in_data_i;
                    end else if (out_fire) begin
                        state_d = StEmpty;
                        main_d  = SET_VAL;
                    end
                end
                StFull: begin
                    // in_ready_o is low here, so only the head can move.
                    if (out_fire) begin
                        state_d = StBusy;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = StEmpty;
                    main_d  = SET_VAL;
                end
            endcase
        end
    end

    // State and payload registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StEmpty;
            main_q  <= SET_VAL;
            skid_q  <= SET_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_pipe_skid_reg;

    localparam int unsigned    DW      = 32;
    localparam logic [DW-1:0]  SET_VAL = 32'h13;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush_i = 1'b0;
    logic          hold_i = 1'b0;
    logic          in_valid_i = 1'b0;
    logic          in_ready_o;
    logic [DW-1:0] in_data_i = '0;
    logic          out_valid_o;
    logic          out_ready_i = 1'b0;
    logic [DW-1:0] out_data_o;
    logic [1:0]    count_o;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mq[$];
    bit            model_ok = 1'b0;

    pipe_skid_reg #(
        .DW      (DW),
        .SET_VAL (SET_VAL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush_i),
        .hold_i      (hold_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .count_o     (count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Reference model: a FIFO of at most two accepted beats.
    always @(posedge clk) begin
        int n;
        n = mq.size();
        if (!rst_n) begin
            mq.delete();
            model_ok = 1'b1;
        end else if (model_ok) begin
            if (flush_i) begin
                mq.delete();
            end else if (!hold_i) begin
                bit ofire, ifire;
                ofire = (n > 0) && out_ready_i;
                ifire = (n < 2) && in_valid_i;
                if (ofire) void'(mq.pop_front());
                if (ifire) mq.push_back(in_data_i);
            end
        end
    end

    // Compare DUT outputs against the model every cycle, mid-period.
    always @(negedge clk) begin
        int n;
        if (model_ok) begin
            n = mq.size();
            chk("count", {30'd0, count_o}, n);
            chk("out_valid", {31'd0, out_valid_o}, {31'd0, (n > 0) && !hold_i});
            chk("in_ready", {31'd0, in_ready_o}, {31'd0, (n < 2) && !hold_i});
            chk("out_data", out_data_o, (n > 0) ? mq[0] : SET_VAL);
        end
    end

    // Apply one cycle of inputs just after the edge, then let outputs settle.
    task automatic drive(input logic r, input logic f, input logic h, input logic iv,
                         input logic [31:0] d, input logic ordy);
        @(posedge clk);
        #1;
        rst_n       = r;
        flush_i     = f;
        hold_i      = h;
        in_valid_i  = iv;
        in_data_i   = d;
        out_ready_i = ordy;
        #1;
    endtask

    initial begin
        // T1 reset
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        chk("t1_valid", {31'd0, out_valid_o}, 32'd0);
        chk("t1_data", out_data_o, 32'h13);
        chk("t1_count", {30'd0, count_o}, 32'd0);
        chk("t1_ready", {31'd0, in_ready_o}, 32'd1);

        // T2 streaming
        drive(1, 0, 0, 1, 32'd1, 1);
        drive(1, 0, 0, 1, 32'd2, 1);
        chk("t2_d1", out_data_o, 32'd1);
        chk("t2_c1", {30'd0, count_o}, 32'd1);
        drive(1, 0, 0, 1, 32'd3, 1);
        chk("t2_d2", out_data_o, 32'd2);
        chk("t2_c2", {30'd0, count_o}, 32'd1);
        drive(1, 0, 0, 0, 32'd0, 1);
        chk("t2_d3", out_data_o, 32'd3);
        drive(1, 0, 0, 0, 32'd0, 1);
        chk("t2_empty", out_data_o, 32'h13);

        // T3 backpressure
        drive(1, 0, 0, 1, 32'hA, 0);
        drive(1, 0, 0, 1, 32'hB, 0);
        chk("t3_hdA", out_data_o, 32'hA);
        drive(1, 0, 0, 1, 32'hC, 0);
        chk("t3_full", {30'd0, count_o}, 32'd2);
        chk("t3_rdy0", {31'd0, in_ready_o}, 32'd0);
        drive(1, 0, 0, 1, 32'hC, 1);
        chk("t3_outA", out_data_o, 32'hA);
        drive(1, 0, 0, 1, 32'hC, 1);
        chk("t3_outB", out_data_o, 32'hB);
        drive(1, 0, 0, 0, 32'h0, 1);
        chk("t3_outC", out_data_o, 32'hC);
        drive(1, 0, 0, 0, 32'h0, 1);
        chk("t3_cnt0", {30'd0, count_o}, 32'd0);

        // T4 flush while full with an in-flight beat
        drive(1, 0, 0, 1, 32'h21, 0);
        drive(1, 0, 0, 1, 32'h22, 0);
        drive(1, 1, 0, 1, 32'h23, 0);
        chk("t4_precnt", {30'd0, count_o}, 32'd2);
        drive(1, 0, 0, 0, 32'h0, 1);
        chk("t4_cnt", {30'd0, count_o}, 32'd0);
        chk("t4_valid", {31'd0, out_valid_o}, 32'd0);
        chk("t4_data", out_data_o, 32'h13);

        // T5 hold for three cycles while busy
        drive(1, 0, 0, 1, 32'h31, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 1, 1, 32'h32, 1);
            chk("t5_rdy", {31'd0, in_ready_o}, 32'd0);
            chk("t5_vld", {31'd0, out_valid_o}, 32'd0);
            chk("t5_main", out_data_o, 32'h31);
        end
        drive(1, 0, 0, 1, 32'h32, 1);
        chk("t5_res31", out_data_o, 32'h31);
        drive(1, 0, 0, 0, 32'h0, 1);
        chk("t5_res32", out_data_o, 32'h32);
        drive(1, 0, 0, 0, 32'h0, 1);

        // T6 random traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive(1, ($urandom_range(0, 99) < 4), ($urandom_range(0, 99) < 15),
                  ($urandom_range(0, 99) < 65), $urandom, ($urandom_range(0, 99) < 60));
        end
        drive(1, 0, 0, 0, 32'h0, 1);
        drive(1, 0, 0, 0, 32'h0, 1);
        drive(1, 0, 0, 0, 32'h0, 1);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
